// File: rtl/dmem_bytelane.sv
// Byte-lane data memory: DEPTH 32-bit words, byte/half/word loads and stores with
// sign/zero extension, one-cycle registered load latency, and a post-reset sweep
// that zeroes every word before requests are accepted.
module dmem_bytelane #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DEPTH  = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    output logic [31:0]       read_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              err
);

    localparam int unsigned IdxW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WordW = ADDR_W - 2;

    typedef enum logic [0:0] {
        StClear,
        StReady
    } state_e;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH];

    logic [WordW-1:0]  word_idx;
    logic [IdxW-1:0]   mem_idx;
    logic [1:0]        lane;
    logic              in_range;
    logic              size_ok;
    logic              align_ok;
    logic              req;
    logic              legal;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [31:0]       rword;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [31:0]       load_val;
    logic              sweep_we;
    logic              store_we;

    assign word_idx = addr[ADDR_W-1:2];
    assign mem_idx  = word_idx[IdxW-1:0];
    assign lane     = addr[1:0];
    // Full-width compare so indices past DEPTH are rejected instead of wrapping.
    assign in_range = (32'(word_idx) < DEPTH);
    assign req      = mem_read | mem_write;

    // Decode access size into lane enables, replicated store data and alignment.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = write_data;
        size_ok   = 1'b1;
        align_ok  = 1'b1;
        case (mem_size)
            2'b00: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{write_data[7:0]}};
            end
            2'b01: begin
                be        = addr[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{write_data[15:0]}};
                align_ok  = ~addr[0];
            end
            2'b10: begin
                be        = 4'b1111;
                align_ok  = (lane == 2'b00);
            end
            default: begin
                size_ok   = 1'b0;
            end
        endcase
    end

    assign legal = (mem_read ^ mem_write) & size_ok & align_ok & in_range;

    // Select and extend the addressed lane(s) of the stored word for a load.
    always_comb begin
        rword  = mem_q[mem_idx];
        byte_v = rword[{lane, 3'b000} +: 8];
        half_v = addr[1] ? rword[31:16] : rword[15:0];
        case (mem_size)
            2'b00:   load_val = {{24{~mem_unsigned & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{~mem_unsigned & half_v[15]}}, half_v};
            default: load_val = rword;
        endcase
    end

    // Next-state, sweep control and request acceptance.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        rd_valid_d = 1'b0;
        err_d      = 1'b0;
        sweep_we   = 1'b0;
        store_we   = 1'b0;
        if (reset) begin
            state_d = StClear;
            idx_d   = '0;
            rdata_d = '0;
        end else begin
            unique case (state_q)
                StClear: begin
                    sweep_we = 1'b1;
                    if (idx_q == IdxW'(DEPTH - 1)) begin
                        state_d = StReady;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IdxW'(1);
                    end
                end
                StReady: begin
                    if (req) begin
                        if (!legal) begin
                            err_d = 1'b1;
                        end else if (mem_read) begin
                            rdata_d    = load_val;
                            rd_valid_d = 1'b1;
                        end else begin
                            store_we = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = StClear;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StClear;
            idx_q      <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    // Storage array: sweep clears one word per cycle, stores update enabled lanes only.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[idx_q] <= '0;
        end else if (store_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= wdata_rep[8*i +: 8];
                end
            end
        end
    end

    assign read_data = rdata_q;
    assign rd_valid  = rd_valid_q;
    assign err       = err_q;
    assign busy      = (state_q == StClear);

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed cases plus randomized traffic
// compared against a byte-oriented reference model of the memory.
module tb_dmem_bytelane;

    localparam int unsigned AW = 9;
    localparam int unsigned D  = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] addr;
    logic [31:0]   write_data;
    logic          mem_read;
    logic          mem_write;
    logic [1:0]    mem_size;
    logic          mem_unsigned;
    logic [31:0]   read_data;
    logic          rd_valid;
    logic          busy;
    logic          err;

    int            n_checks = 0;
    int            n_errors = 0;
    logic [31:0]   model [D];
    logic [31:0]   exp_rdata;

    dmem_bytelane #(
        .ADDR_W(AW),
        .DEPTH (D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .write_data  (write_data),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_size    (mem_size),
        .mem_unsigned(mem_unsigned),
        .read_data   (read_data),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // Reference rules: one of read/write, a real size, word in range, naturally aligned.
    function automatic bit ref_legal(input bit r, input bit w, input logic [1:0] sz,
                                     input int a);
        int nbytes;
        if (r == w) return 1'b0;
        if (sz == 2'b11) return 1'b0;
        if ((a / 4) >= int'(D)) return 1'b0;
        nbytes = 1 << sz;
        if ((a % nbytes) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns, input int a);
        int          nbytes;
        longint      v;
        logic [31:0] w;
        nbytes = 1 << sz;
        v      = 0;
        w      = model[a / 4];
        for (int k = 0; k < nbytes; k++) begin
            v += longint'((w >> (8 * ((a % 4) + k))) & 32'hFF) << (8 * k);
        end
        if (!uns && nbytes < 4 && v >= (longint'(1) << (8 * nbytes - 1))) begin
            v -= longint'(1) << (8 * nbytes);
        end
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [1:0] sz, input int a, input logic [31:0] wd);
        int nbytes;
        int ln;
        nbytes = 1 << sz;
        for (int k = 0; k < nbytes; k++) begin
            ln = (a % 4) + k;
            model[a / 4][8*ln +: 8] = wd[8*k +: 8];
        end
    endtask

    // Reference behaviour of one READY-state cycle; returns expected pulses.
    task automatic model_step(input bit r, input bit w, input logic [1:0] sz, input bit u,
                              input int a, input logic [31:0] wd,
                              output bit exp_v, output bit exp_e);
        exp_v = 1'b0;
        exp_e = 1'b0;
        if (r || w) begin
            if (!ref_legal(r, w, sz, a)) begin
                exp_e = 1'b1;
            end else if (r) begin
                exp_rdata = ref_load(sz, u, a);
                exp_v     = 1'b1;
            end else begin
                ref_store(sz, a, wd);
            end
        end
    endtask

    // Present one request for a single rising edge; outputs are stable on return.
    task automatic drive(input bit r, input bit w, input logic [1:0] sz, input bit u,
                         input int a, input logic [31:0] wd);
        @(negedge clk);
        mem_read     = r;
        mem_write    = w;
        mem_size     = sz;
        mem_unsigned = u;
        addr         = a[AW-1:0];
        write_data   = wd;
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(D); i++) model[i] = 32'h0;
        exp_rdata = 32'h0;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Count sampled cycles with busy high, starting from the current sample.
    task automatic count_busy(output int cnt);
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 200 && busy; i++) begin
            @(posedge clk);
            #1;
            if (busy) cnt++;
        end
    endtask

    task automatic test_reset();
        int cnt;
        do_reset();
        n_checks++;
        if ({busy, rd_valid, err} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_flags: got busy/rd_valid/err=%b, required 100",
                     {busy, rd_valid, err});
        end
        n_checks++;
        if (read_data !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_rdata: got %h, required 00000000", read_data);
        end
        release_reset();
        count_busy(cnt);
        n_checks++;
        if (cnt != int'(D)) begin
            n_errors++;
            $display("FAIL busy_len: got %0d cycles, required %0d", cnt, D);
        end
        drive(1, 0, 2'b10, 0, 'hFC, 0);
        n_checks++;
        if ({rd_valid, err, read_data} !== {2'b10, 32'h0}) begin
            n_errors++;
            $display("FAIL first_load: got v=%b e=%b rd=%h, required v=1 e=0 rd=00000000",
                     rd_valid, err, read_data);
        end
        drive(0, 0, 2'b00, 0, 0, 0);
        n_checks++;
        if ({rd_valid, err} !== 2'b00) begin
            n_errors++;
            $display("FAIL rd_valid_pulse: got v=%b e=%b, required v=0 e=0", rd_valid, err);
        end
    endtask

    task automatic test_extend();
        bit v, e;
        logic [31:0] exp_tab [7];
        exp_tab = '{32'h0000_00F1, 32'hFFFF_FFF1, 32'hFFFF_8000, 32'h1122_AB44,
                    32'hBEEF_0000, 32'h0000_BEEF, 32'hFFFF_BEEF};
        drive(0, 1, 2'b10, 0, 'h10, 32'h8000_00F1);
        model_step(0, 1, 2'b10, 0, 'h10, 32'h8000_00F1, v, e);
        drive(1, 0, 2'b00, 1, 'h10, 0);
        model_step(1, 0, 2'b00, 1, 'h10, 0, v, e);
        n_checks++;
        if (read_data !== exp_tab[0] || !rd_valid) begin
            n_errors++;
            $display("FAIL lbu_10: got %h v=%b, required %h v=1", read_data, rd_valid, exp_tab[0]);
        end
        drive(1, 0, 2'b00, 0, 'h10, 0);
        model_step(1, 0, 2'b00, 0, 'h10, 0, v, e);
        n_checks++;
        if (read_data !== exp_tab[1] || !rd_valid) begin
            n_errors++;
            $display("FAIL lb_10: got %h v=%b, required %h v=1", read_data, rd_valid, exp_tab[1]);
        end
        drive(1, 0, 2'b01, 0, 'h12, 0);
        model_step(1, 0, 2'b01, 0, 'h12, 0, v, e);
        n_checks++;
        if (read_data !== exp_tab[2] || !rd_valid) begin
            n_errors++;
            $display("FAIL lh_12: got %h v=%b, required %h v=1", read_data, rd_valid, exp_tab[2]);
        end
        drive(0, 1, 2'b10, 0, 'h20, 32'h1122_3344);
        model_step(0, 1, 2'b10, 0, 'h20, 32'h1122_3344, v, e);
        drive(0, 1, 2'b00, 0, 'h21, 32'h0000_00AB);
        model_step(0, 1, 2'b00, 0, 'h21, 32'h0000_00AB, v, e);
        drive(1, 0, 2'b10, 0, 'h20, 0);
        model_step(1, 0, 2'b10, 0, 'h20, 0, v, e);
        n_checks++;
        if (read_data !== exp_tab[3] || !rd_valid) begin
            n_errors++;
            $display("FAIL sb_merge: got %h v=%b, required %h v=1", read_data, rd_valid, exp_tab[3]);
        end
        drive(0, 1, 2'b10, 0, 'h24, 0);
        model_step(0, 1, 2'b10, 0, 'h24, 0, v, e);
        drive(0, 1, 2'b01, 0, 'h26, 32'h1234_BEEF);
        model_step(0, 1, 2'b01, 0, 'h26, 32'h1234_BEEF, v, e);
        for (int i = 0; i < 3; i++) begin
            logic [1:0] sz;
            int         a;
            bit         u;
            sz = (i == 0) ? 2'b10 : 2'b01;
            a  = (i == 0) ? 'h24 : 'h26;
            u  = (i == 1);
            drive(1, 0, sz, u, a, 0);
            model_step(1, 0, sz, u, a, 0, v, e);
            n_checks++;
            if (read_data !== exp_tab[4+i] || !rd_valid) begin
                n_errors++;
                $display("FAIL sh_upper_%0d: got %h v=%b, required %h v=1", i, read_data,
                         rd_valid, exp_tab[4+i]);
            end
        end
    endtask

    task automatic test_illegal();
        bit v, e;
        logic [31:0] held;
        held = exp_rdata;
        for (int i = 0; i < 6; i++) begin
            bit r, w;
            logic [1:0] sz;
            int a;
            logic [31:0] wd;
            case (i)
                0:       begin r = 1; w = 0; sz = 2'b01; a = 'h13;  wd = 0; end
                1:       begin r = 0; w = 1; sz = 2'b10; a = 'h22;  wd = 32'hFFFF_FFFF; end
                2:       begin r = 1; w = 0; sz = 2'b11; a = 'h10;  wd = 0; end
                3:       begin r = 1; w = 1; sz = 2'b10; a = 'h10;  wd = 0; end
                4:       begin r = 1; w = 0; sz = 2'b10; a = 'h100; wd = 0; end
                default: begin r = 0; w = 1; sz = 2'b10; a = 'h100; wd = 32'h55; end
            endcase
            drive(r, w, sz, 0, a, wd);
            model_step(r, w, sz, 0, a, wd, v, e);
            n_checks++;
            if ({rd_valid, err, read_data} !== {2'b01, held}) begin
                n_errors++;
                $display("FAIL illegal_%0d: got v=%b e=%b rd=%h, required v=0 e=1 rd=%h",
                         i, rd_valid, err, read_data, held);
            end
        end
        drive(0, 0, 2'b00, 0, 0, 0);
        n_checks++;
        if ({rd_valid, err} !== 2'b00) begin
            n_errors++;
            $display("FAIL err_pulse: got v=%b e=%b, required v=0 e=0", rd_valid, err);
        end
        for (int i = 0; i < 3; i++) begin
            int a;
            a = (i == 0) ? 'h20 : (i == 1) ? 'h10 : 'h0;
            drive(1, 0, 2'b10, 0, a, 0);
            model_step(1, 0, 2'b10, 0, a, 0, v, e);
            n_checks++;
            if ({rd_valid, err, read_data} !== {v, e, exp_rdata}) begin
                n_errors++;
                $display("FAIL unchanged_%0d: got v=%b e=%b rd=%h, required v=%b e=%b rd=%h",
                         i, rd_valid, err, read_data, v, e, exp_rdata);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit v, e;
        logic [31:0] vals [4];
        vals = '{32'hCAFE_F00D, 32'h0000_005A, 32'h0000_9876, 32'h0};
        for (int i = 0; i < 4; i++) begin
            bit r, w;
            logic [1:0] sz;
            int a;
            r  = (i == 3);
            w  = !r;
            sz = (i == 1) ? 2'b00 : (i == 2) ? 2'b01 : 2'b10;
            a  = (i == 1) ? 'h41 : (i == 2) ? 'h42 : 'h40;
            drive(r, w, sz, 1, a, vals[i]);
            model_step(r, w, sz, 1, a, vals[i], v, e);
        end
        n_checks++;
        if ({rd_valid, err, read_data} !== {2'b10, exp_rdata}) begin
            n_errors++;
            $display("FAIL b2b_load: got v=%b e=%b rd=%h, required v=1 e=0 rd=%h",
                     rd_valid, err, read_data, exp_rdata);
        end
    endtask

    task automatic test_random();
        bit v, e;
        for (int n = 0; n < 500; n++) begin
            int sel, a, nb;
            bit r, w, u;
            logic [1:0] sz;
            logic [31:0] wd;
            sel = $urandom_range(0, 9);
            r   = (sel == 1) || (sel >= 2 && sel <= 5);
            w   = (sel == 1) || (sel >= 6);
            sz  = 2'($urandom_range(0, 3));
            u   = 1'($urandom_range(0, 1));
            wd  = $urandom;
            a   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 511))
                                              : int'($urandom_range(0, 255));
            nb  = (sz == 2'b11) ? 1 : (1 << sz);
            if ($urandom_range(0, 1) == 1) a = a - (a % nb);
            drive(r, w, sz, u, a, wd);
            model_step(r, w, sz, u, a, wd, v, e);
            n_checks++;
            if ({rd_valid, err, read_data} !== {v, e, exp_rdata}) begin
                n_errors++;
                $display("FAIL random_%0d r=%b w=%b sz=%0d u=%b a=%h: got v=%b e=%b rd=%h, required v=%b e=%b rd=%h",
                         n, r, w, sz, u, a, rd_valid, err, read_data, v, e, exp_rdata);
            end
        end
    endtask

    task automatic test_busy_ignore();
        int cnt;
        bit v, e;
        do_reset();
        release_reset();
        repeat (10) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            drive(i != 1, i != 0, 2'b10, 0, 'h8, 32'hDEAD_BEEF);
            n_checks++;
            if ({busy, rd_valid, err} !== 3'b100) begin
                n_errors++;
                $display("FAIL busy_req_%0d: got busy/v/e=%b, required 100", i,
                         {busy, rd_valid, err});
            end
        end
        count_busy(cnt);
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL busy_end: got busy=%b, required 0", busy);
        end
        for (int i = 0; i < int'(D); i++) begin
            drive(1, 0, 2'b10, 0, 4 * i, 0);
            model_step(1, 0, 2'b10, 0, 4 * i, 0, v, e);
            n_checks++;
            if ({rd_valid, read_data} !== {1'b1, 32'h0}) begin
                n_errors++;
                $display("FAIL cleared_word_%0d: got v=%b rd=%h, required v=1 rd=00000000",
                         i, rd_valid, read_data);
            end
        end
    endtask

    task automatic test_mid_reset();
        int cnt;
        bit v, e;
        drive(0, 1, 2'b10, 0, 'h30, 32'h0BAD_CAFE);
        model_step(0, 1, 2'b10, 0, 'h30, 32'h0BAD_CAFE, v, e);
        // Request in the same cycle as reset must be discarded.
        @(negedge clk);
        reset        = 1'b1;
        mem_read     = 1'b0;
        mem_write    = 1'b1;
        mem_size     = 2'b10;
        addr         = 'h34;
        write_data   = 32'h1111_1111;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        for (int i = 0; i < int'(D); i++) model[i] = 32'h0;
        exp_rdata = 32'h0;
        release_reset();
        repeat (30) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        release_reset();
        count_busy(cnt);
        n_checks++;
        if (cnt != int'(D)) begin
            n_errors++;
            $display("FAIL mid_reset_busy: got %0d cycles, required %0d", cnt, D);
        end
        drive(1, 0, 2'b10, 0, 'h30, 0);
        n_checks++;
        if ({rd_valid, read_data} !== {1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL mid_reset_word: got v=%b rd=%h, required v=1 rd=00000000",
                     rd_valid, read_data);
        end
        drive(0, 1, 2'b10, 0, 'h30, 32'h7777_0001);
        drive(1, 0, 2'b10, 0, 'h30, 0);
        do_reset();
        n_checks++;
        if ({busy, rd_valid, err, read_data} !== {3'b100, 32'h0}) begin
            n_errors++;
            $display("FAIL reset_from_ready: got busy/v/e=%b rd=%h, required 100 rd=00000000",
                     {busy, rd_valid, err}, read_data);
        end
        release_reset();
        count_busy(cnt);
    endtask

    initial begin
        reset        = 1'b1;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_size     = 2'b00;
        mem_unsigned = 1'b0;
        addr         = '0;
        write_data   = '0;
        exp_rdata    = 32'h0;
        test_reset();
        test_extend();
        test_illegal();
        test_back_to_back();
        test_random();
        test_busy_ignore();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
